dtack_wait_gen: RTL and testbench

Bus-cycle terminator downstream of AddressDecoder on the 68010 board. It consumes the decoded chip selects and CPU address strobe, and returns o_DTACK_n after a per-region programmable wait-state count. For I/O and expansion cycles it waits for the device's own acknowledge. A watchdog asserts o_BERR_n on unmapped or hung cycles.

---
 rtl/dtack_wait_gen.sv | 157 +++++++++++++++
 tb/tb_dtack_wait_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtack_wait_gen.sv
// Bus-cycle terminator for the 68010 board: DTACK after per-region wait states,
// device-acknowledged I/O and expansion cycles, BERR from a saturating watchdog.
module dtack_wait_gen #(
   parameter int ROM_WAIT = 2,
   parameter int RAM_WAIT = 0,
   parameter int TIMEOUT  = 64,
   parameter int CNT_W    = 8
) (
   input  logic i_CLK,
   input  logic i_HWRST,
   input  logic i_AS_n,
   input  logic i_ROMSEL_n,
   input  logic i_RAMSEL_n,
   input  logic i_IOSEL_n,
   input  logic i_EXPSEL_n,
   input  logic i_IODTACK_n,
   input  logic i_EXPDTACK_n,
   output logic o_DTACK_n,
   output logic o_BERR_n,
   output logic o_WAITING
);

   typedef enum logic [1:0] {IDLE, WAIT, ACK, BERR} state_t;
   typedef enum logic [2:0] {RG_ROM, RG_RAM, RG_IO, RG_EXP, RG_UNM} region_t;

   localparam logic [CNT_W-1:0] ROM_W   = CNT_W'(ROM_WAIT);
   localparam logic [CNT_W-1:0] RAM_W   = CNT_W'(RAM_WAIT);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TO_SAT  = CNT_W'(TIMEOUT);

   logic             as_m, as_s, as_d;
   logic             iod_m, iod_s;
   logic             expd_m, expd_s;
   logic [1:0]       fill;
   logic             armed;
   state_t           state;
   region_t          region, sel_region;
   logic [CNT_W-1:0] wcnt, wdog, sel_wait;
   logic             sel_internal, internal, cyc_start, ext_ack, ack_cond;

   always_comb begin
      sel_region = RG_UNM;
      sel_wait   = '0;
      if (!i_ROMSEL_n) begin
         sel_region = RG_ROM;
         sel_wait   = ROM_W;
      end else if (!i_RAMSEL_n) begin
         sel_region = RG_RAM;
         sel_wait   = RAM_W;
      end else if (!i_IOSEL_n) begin
         sel_region = RG_IO;
      end else if (!i_EXPSEL_n) begin
         sel_region = RG_EXP;
      end
   end

   assign sel_internal = (sel_region == RG_ROM) || (sel_region == RG_RAM);
   assign internal     = (region == RG_ROM) || (region == RG_RAM);

   // armed blocks a start until as_s has been seen high on real post-reset
   // data, so a strobe held low across reset is never treated as a new cycle.
   assign cyc_start = armed & ~as_s & as_d;

   always_comb begin
      ext_ack = 1'b0;
      case (region)
         RG_IO:   ext_ack = ~iod_s;
         RG_EXP:  ext_ack = ~expd_s;
         default: ext_ack = 1'b0;
      endcase
   end

   assign ack_cond = internal ? (wcnt == CNT_W'(1)) : ext_ack;

   always_ff @(posedge i_CLK) begin
      if (i_HWRST) begin
         as_m      <= 1'b1;
         as_s      <= 1'b1;
         as_d      <= 1'b1;
         iod_m     <= 1'b1;
         iod_s     <= 1'b1;
         expd_m    <= 1'b1;
         expd_s    <= 1'b1;
         fill      <= 2'd0;
         armed     <= 1'b0;
         state     <= IDLE;
         region    <= RG_UNM;
         wcnt      <= '0;
         wdog      <= '0;
         o_DTACK_n <= 1'b1;
         o_BERR_n  <= 1'b1;
         o_WAITING <= 1'b0;
      end else begin
         as_m   <= i_AS_n;
         as_s   <= as_m;
         as_d   <= as_s;
         iod_m  <= i_IODTACK_n;
         iod_s  <= iod_m;
         expd_m <= i_EXPDTACK_n;
         expd_s <= expd_m;

         if (fill != 2'd2)
            fill <= fill + 2'd1;
         else if (as_s)
            armed <= 1'b1;

         // Outputs follow the next state; branches below override the defaults.
         o_DTACK_n <= 1'b1;
         o_BERR_n  <= 1'b1;
         o_WAITING <= 1'b0;

         case (state)
            IDLE: begin
               if (cyc_start) begin
                  region <= sel_region;
                  wcnt   <= sel_wait;
                  wdog   <= '0;
                  if (sel_internal && (sel_wait == '0)) begin
                     state     <= ACK;
                     o_DTACK_n <= 1'b0;
                  end else begin
                     state     <= WAIT;
                     o_WAITING <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (wdog != TO_SAT)
                  wdog <= wdog + 1'b1;
               if (as_s) begin
                  state <= IDLE;
               end else if (ack_cond) begin
                  state     <= ACK;
                  o_DTACK_n <= 1'b0;
               end else if (wdog == TO_LAST) begin
                  state    <= BERR;
                  o_BERR_n <= 1'b0;
               end else begin
                  o_WAITING <= 1'b1;
                  if (internal)
                     wcnt <= wcnt - 1'b1;
               end
            end
            ACK: begin
               if (as_s) state <= IDLE;
               else      o_DTACK_n <= 1'b0;
            end
            BERR: begin
               if (as_s) state <= IDLE;
               else      o_BERR_n <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dtack_wait_gen.sv
// Scoreboard bench for dtack_wait_gen: stimulus predicts DTACK/BERR edges and
// their clock numbers from the timing rules; a negedge monitor checks them.
module tb_dtack_wait_gen;

   localparam int ROM_WAIT = 2;
   localparam int RAM_WAIT = 0;
   localparam int TIMEOUT  = 64;
   localparam int CNT_W    = 8;

   localparam int EV_DF = 0;  // DTACK falls
   localparam int EV_BF = 1;  // BERR falls
   localparam int EV_DR = 2;  // DTACK rises
   localparam int EV_BR = 3;  // BERR rises

   typedef struct {
      int kind;
      int at;
      int waits;  // expected o_WAITING cycles before this event, -1 = don't care
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic as_n = 1'b1;
   logic romsel_n = 1'b1, ramsel_n = 1'b1, iosel_n = 1'b1, expsel_n = 1'b1;
   logic iodtack_n = 1'b1, expdtack_n = 1'b1;
   logic dtack_n, berr_n, waiting;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   wcount = 0;
   logic pd = 1'b1, pb = 1'b1;
   exp_t sb[$];

   dtack_wait_gen #(
      .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .i_CLK(clk),
      .i_HWRST(rst),
      .i_AS_n(as_n),
      .i_ROMSEL_n(romsel_n),
      .i_RAMSEL_n(ramsel_n),
      .i_IOSEL_n(iosel_n),
      .i_EXPSEL_n(expsel_n),
      .i_IODTACK_n(iodtack_n),
      .i_EXPDTACK_n(expdtack_n),
      .o_DTACK_n(dtack_n),
      .o_BERR_n(berr_n),
      .o_WAITING(waiting)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
      $fatal(1);
   end

   // ---------------- monitor ----------------
   task automatic check_ev(input int kind);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL event: unexpected kind %0d at cycle %0d", kind, cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.at != cyc) begin
            n_fail++;
            $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     kind, cyc, e.kind, e.at);
         end
         if (e.waits >= 0) begin
            n_checks++;
            if (wcount != e.waits) begin
               n_fail++;
               $display("FAIL waiting_len: got %0d cycles, expected %0d (event at %0d)",
                        wcount, e.waits, cyc);
            end
         end
      end
      wcount = 0;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         wcount = 0;
      end else begin
         if (waiting === 1'b1) wcount++;
         n_checks++;
         if (dtack_n === 1'b0 && berr_n === 1'b0) begin
            n_fail++;
            $display("FAIL both_low: DTACK_n=0 and BERR_n=0 at cycle %0d", cyc);
         end
         if (dtack_n !== pd) check_ev(dtack_n ? EV_DR : EV_DF);
         if (berr_n !== pb)  check_ev(berr_n ? EV_BR : EV_BF);
      end
      pd = dtack_n;
      pb = berr_n;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   // sel_n = {ROM, RAM, IO, EXP}; ack_dly = clocks after T the device acks (-1 never)
   task automatic bus_cycle(input logic [3:0] sel_n, input int ack_dly, input int hold);
      int   t, f, ea, er, kind, region;
      exp_t e;
      tick();
      t  = cyc + 2;  // as_s goes low two edges after the strobe is driven
      as_n = 1'b0;
      {romsel_n, ramsel_n, iosel_n, expsel_n} = sel_n;
      if      (!sel_n[3]) region = 0;
      else if (!sel_n[2]) region = 1;
      else if (!sel_n[1]) region = 2;
      else if (!sel_n[0]) region = 3;
      else                region = 4;
      ea = -1;
      kind = EV_BF;
      f = t + TIMEOUT + 1;
      case (region)
         0: begin kind = EV_DF; f = t + ROM_WAIT + 1; end
         1: begin kind = EV_DF; f = t + RAM_WAIT + 1; end
         2, 3: begin
            if (ack_dly >= 0) begin
               ea = t + ack_dly;
               if (((ea + 3 > t + 2) ? ea + 3 : t + 2) <= t + TIMEOUT + 1) begin
                  kind = EV_DF;
                  f = (ea + 3 > t + 2) ? ea + 3 : t + 2;
               end
            end
         end
         default: ;
      endcase
      e = '{kind, f, f - 1 - t};
      sb.push_back(e);
      er = f + hold;
      while (cyc < er) begin
         tick();
         if (cyc == ea) begin
            if (region == 2) iodtack_n = 1'b0;
            else             expdtack_n = 1'b0;
         end
      end
      as_n = 1'b1;
      {romsel_n, ramsel_n, iosel_n, expsel_n} = 4'hF;
      iodtack_n  = 1'b1;
      expdtack_n = 1'b1;
      e = '{kind + 2, er + 3, -1};
      sb.push_back(e);
      repeat (3 + $urandom_range(0, 3)) tick();
   endtask

   initial begin
      logic [3:0] s;
      int         d;
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("reset_dtack", dtack_n, 1'b1);
      chk("reset_berr", berr_n, 1'b1);
      chk("reset_waiting", waiting, 1'b0);
      tick();
      rst = 1'b0;
      repeat (5) tick();

      bus_cycle(4'b0111, -1, 1);            // ROM, 2 wait states
      bus_cycle(4'b1011, -1, 0);            // RAM, back to back
      bus_cycle(4'b1011, -1, 2);
      bus_cycle(4'b1101, 10, 1);            // IO acked 10 clocks after T
      bus_cycle(4'b1111, -1, 1);            // unmapped -> BERR
      bus_cycle(4'b1110, TIMEOUT - 2, 0);   // EXP ack lands on watchdog expiry
      bus_cycle(4'b1110, TIMEOUT - 1, 0);   // one clock too late -> BERR
      bus_cycle(4'b0000, 3, 0);             // all selected: ROM wins
      bus_cycle(4'b1100, 5, 2);             // IO beats EXP

      // Reset in the middle of a ROM wait with the strobe held low.
      tick();
      as_n = 1'b0;
      romsel_n = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("rst_hold_dtack", dtack_n, 1'b1);
      chk("rst_hold_waiting", waiting, 1'b0);
      as_n = 1'b1;
      romsel_n = 1'b1;
      repeat (4) tick();
      bus_cycle(4'b0111, -1, 1);

      for (int i = 0; i < 25; i++) begin
         s = 4'($urandom_range(0, 15));
         d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 30));
         bus_cycle(s, d, int'($urandom_range(0, 4)));
      end

      repeat (10) tick();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected events never seen, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
